// File: rtl/nrd_seq_ctrl_pkg.sv
// nrd_seq_pkg: shared state encoding, default width and counter sizing for the divider.
package nrd_seq_pkg;
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;
  localparam int W_DEF = 48;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
  localparam int CNT_W = cnt_w(W_DEF);
endpackage

// File: rtl/nrd_seq_ctrl_if.sv
// nrd_seq_ctrl_if: request/result bundle between a requester and the divider.
interface nrd_seq_ctrl_if
  import nrd_seq_pkg::*;
#(
  parameter int W = W_DEF
);
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, dbz);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, dbz);
endinterface

// File: rtl/nrd_seq_ctrl_step.sv
// nrd_step: one non-restoring iteration, or the final remainder correction when fix_i is set.
module nrd_step
  import nrd_seq_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W:0]   a_i,
  input  logic [W-1:0] q_i,
  input  logic [W:0]   b_i,
  input  logic         fix_i,
  output logic [W:0]   a_o,
  output logic [W-1:0] q_o
);
  logic [W:0] x;
  logic [W:0] y;
  logic       cin;
  // subtraction is ~B plus a carry-in of one; correction adds B or nothing
  always_comb begin
    x   = fix_i ? a_i : {a_i[W-1:0], q_i[W-1]};
    y   = a_i[W] ? b_i : (fix_i ? '0 : ~b_i);
    cin = !fix_i && !a_i[W];
    a_o = x + y + {{W{1'b0}}, cin};
    q_o = {q_i[W-2:0], ~a_o[W]};
  end
endmodule

// File: rtl/nrd_seq_ctrl.sv
// nrd_seq_ctrl: sequential non-restoring unsigned divider, one quotient bit per cycle.
module nrd_seq_ctrl
  import nrd_seq_pkg::*;
#(
  parameter int W = W_DEF
) (
  input logic          clk,
  input logic          rst,
  nrd_seq_ctrl_if.slave bus
);
  localparam int CW = cnt_w(W);
  state_e        state_q;
  logic [W:0]    a_q;
  logic [W:0]    b_q;
  logic [W:0]    a_d;
  logic [W-1:0]  q_q;
  logic [W-1:0]  q_d;
  logic [W-1:0]  quot_q;
  logic [W-1:0]  rem_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          dbz_q;
  nrd_step #(.W(W)) u_step (
    .a_i  (a_q),
    .q_i  (q_q),
    .b_i  (b_q),
    .fix_i(state_q == FIX),
    .a_o  (a_d),
    .q_o  (q_d)
  );
  // a zero divisor leaves B==0, which is how DONE tells the two paths apart
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= state_q == ITER || state_q == FIX;
      unique case (state_q)
        IDLE: if (bus.start && !done_q) begin
          b_q     <= {1'b0, bus.divisor};
          cnt_q   <= '0;
          a_q     <= bus.divisor == '0 ? {1'b0, bus.dividend} : '0;
          q_q     <= bus.divisor == '0 ? '1 : bus.dividend;
          state_q <= bus.divisor == '0 ? DONE : ITER;
        end
        ITER: begin
          a_q   <= a_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) state_q <= FIX;
        end
        FIX: begin
          a_q     <= a_d;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          quot_q  <= q_q;
          rem_q   <= a_q[W-1:0];
          dbz_q   <= b_q == '0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.dbz       = dbz_q;
endmodule

// File: tb/tb_nrd_seq_ctrl.sv
// tb_nrd_seq_ctrl: directed and back-to-back random checks of nrd_seq_ctrl against an arithmetic model.
module tb_nrd_seq_ctrl;
  import nrd_seq_pkg::*;
  localparam int W = 48;
  localparam logic [W-1:0] ONES = '1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;
  nrd_seq_ctrl_if #(.W(W)) bus ();
  nrd_seq_ctrl #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // model: an accepted start at edge e finishes at e+1 (zero divisor) or e+W+2
  int           acc_edge = -100;
  int           done_edge = -100;
  int           free_edge = 0;
  logic         m_z = 1'b0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_r = '0;
  logic         h_z = 1'b0;
  logic [W-1:0] h_q = '0;
  logic [W-1:0] h_r = '0;
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      acc_edge = -100;
      done_edge = -100;
      free_edge = 0;
      h_q = '0;
      h_r = '0;
      h_z = 1'b0;
    end else begin
      if (cyc == done_edge) begin
        h_q = m_q;
        h_r = m_r;
        h_z = m_z;
      end
      if (bus.start && cyc >= free_edge) begin
        m_z = bus.divisor == '0;
        m_q = m_z ? ONES : bus.dividend / bus.divisor;
        m_r = m_z ? bus.dividend : bus.dividend % bus.divisor;
        acc_edge = cyc;
        done_edge = cyc + (m_z ? 1 : W + 2);
        free_edge = done_edge + 2;
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) if (cmp_en) begin
    chk("done", 64'(bus.done), 64'(cyc == done_edge));
    chk("busy", 64'(bus.busy), 64'(!m_z && cyc > acc_edge && cyc < done_edge));
    chk("quotient", 64'(bus.quotient), 64'(h_q));
    chk("remainder", 64'(bus.remainder), 64'(h_r));
    chk("dbz", 64'(bus.dbz), 64'(h_z));
  end
  function automatic logic [W-1:0] rnd();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0] >> $urandom_range(0, W - 1);
  endfunction
  function automatic logic [W-1:0] rnd_dv();
    int k;
    k = $urandom_range(0, 3);
    return k == 0 ? '0 : (k == 1 ? rnd() & W'(8'hFF) : rnd());
  endfunction
  task automatic op(input logic [W-1:0] dd, input logic [W-1:0] dv, input int lat,
                    input logic [W-1:0] q, input logic [W-1:0] r, input logic z, input int nb_exp);
    int t0;
    int n;
    int nb;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = dd;
    bus.divisor = dv;
    t0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dividend = rnd();
    bus.divisor = rnd();
    n = 0;
    nb = 0;
    while (!bus.done && n < 200) begin
      nb += int'(bus.busy);
      @(negedge clk);
      bus.dividend = rnd();
      bus.divisor = rnd();
      n++;
    end
    chk("latency", 64'(cyc - t0), 64'(lat));
    chk("busy_cycles", 64'(nb), 64'(nb_exp));
    chk("op_quotient", 64'(bus.quotient), 64'(q));
    chk("op_remainder", 64'(bus.remainder), 64'(r));
    chk("op_dbz", 64'(bus.dbz), 64'(z));
  endtask
  initial begin
    int t0;
    int nd;
    int g;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_quotient", 64'(bus.quotient), 64'd0);
    chk("rst_remainder", 64'(bus.remainder), 64'd0);
    chk("rst_dbz", 64'(bus.dbz), 64'd0);
    cmp_en = 1'b1;
    op(100, 7, 50, 14, 2, 1'b0, 49);
    op(ONES, 1, 50, ONES, 0, 1'b0, 49);
    op(5, 9, 50, 0, 5, 1'b0, 49);
    op(123, 0, 1, ONES, 123, 1'b1, 0);
    op(77, 77, 50, 1, 0, 1'b0, 49);
    op(0, 5, 50, 0, 0, 1'b0, 49);
    op(ONES, ONES - 1, 50, 1, 1, 1'b0, 49);
    op(48'h123456789ABC, 48'h1000, 50, 48'h123456789, 48'hABC, 1'b0, 49);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 5000;
    bus.divisor = 3;
    t0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < t0 + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_quotient", 64'(bus.quotient), 64'd0);
    chk("abort_remainder", 64'(bus.remainder), 64'd0);
    chk("abort_dbz", 64'(bus.dbz), 64'd0);
    nd = 0;
    repeat (60) begin
      @(negedge clk);
      nd += int'(bus.done);
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    op(1000, 10, 50, 100, 0, 1'b0, 49);
    nd = 0;
    g = 0;
    bus.start = 1'b1;
    while (nd < 1000 && g < 90000) begin
      @(negedge clk);
      if (bus.done) nd++;
      bus.dividend = rnd();
      bus.divisor = rnd_dv();
      g++;
    end
    bus.start = 1'b0;
    chk("b2b_ops", 64'(nd), 64'd1000);
    repeat (60) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
